l1_dcache_write_buffer: RTL and testbench

Write buffer and memory-side sequencer between the L1 data cache's memory port and backing RAM. It absorbs cache write-backs into a small FIFO, returns read-refill data, and drains buffered writes to RAM when the port is otherwise idle. Reads take priority over drains, and reads that hit a buffered address are ordered correctly (forwarded or drained first). Downstream neighbour of the L1 data cache.

---
 rtl/l1_mem_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/l1_dcache_write_buffer.sv | 181 ++++++++++++++++++
 tb/tb_l1_dcache_write_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_pkg.sv
// Shared types and default sizes for the L1 data-cache write buffer.
package l1_mem_pkg;

    localparam int unsigned WB_DEPTH  = 4;
    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    // Memory-side sequencer states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_ISSUE = 2'd1,
        READ_RESP  = 2'd2,
        DRAIN      = 2'd3
    } wb_state_t;

    // One buffered write-back
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write-buffer FIFO; exposes every slot, the head pointer and a
// valid mask so the parent can search entries in age order.
module wb_fifo
    import l1_mem_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  wb_entry_t                     push_entry_i,
    input  logic                          pop_i,
    output logic [$clog2(DEPTH)-1:0]      head_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o,
    output wb_entry_t [DEPTH-1:0]         entries_o,
    output logic [DEPTH-1:0]              valid_c_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, slot_off;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, push_ok, pop_ok;

    // Pointer/count update; a push always wins so both never commit together
    always_comb begin
        push_ok = push_i && (count_q != CNT_FULL);
        pop_ok  = pop_i && !push_i && (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok) begin
            head_d  = head_q + PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
        end
    end

    // Entry storage needs no reset; the valid mask qualifies it
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    // A slot is live when its distance from head is below the count
    always_comb begin
        valid_c_o = '0;
        slot_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off     = PTR_W'(i) - head_q;
            valid_c_o[i] = (CNT_W'(slot_off) < count_q);
        end
    end

    assign head_o    = head_q;
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/l1_dcache_write_buffer.sv
// L1 data-cache write buffer and RAM-side sequencer.
// Optional feature macro: L1_WB_FORWARD_EN (serve buffer-hit reads from the buffer).
module l1_dcache_write_buffer
    import l1_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cache_mem_request,
    input  logic                       cache_mem_write_enable,
    input  logic [ADDR_W-1:0]          cache_mem_address,
    input  logic [DATA_W-1:0]          cache_mem_write_data,
    output logic                       cache_mem_ready,
    output logic [DATA_W-1:0]          cache_mem_response_data,
    output logic                       cache_mem_resp_valid,
    output logic                       mem_request,
    output logic                       mem_write_enable,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_write_data,
    input  logic [DATA_W-1:0]          mem_response_data,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH+1)-1:0] wb_count,
    output logic                       wb_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
`ifdef L1_WB_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    wb_state_t             state_q, state_d;
    logic                  mem_request_q, mem_request_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d, resp_data_q, resp_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  is_read_c, is_write_c, hit_c, start_drain_c, push_c, pop_c;
    logic [DATA_W-1:0]     hit_data_c;
    logic [PTR_W-1:0]      head, idx_c;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                  full;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    wb_entry_t             head_entry_c, push_entry_c;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_c),
        .push_entry_i (push_entry_c),
        .pop_i        (pop_c),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full),
        .entries_o    (entries),
        .valid_c_o    (valid)
    );

    assign is_read_c    = cache_mem_request && !cache_mem_write_enable;
    assign is_write_c   = cache_mem_request && cache_mem_write_enable;
    assign head_entry_c = entries[head];

    // Youngest-match search: walk from head so the last hit is the newest
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        idx_c      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_c = head + PTR_W'(k);
            if (valid[idx_c] && (entries[idx_c].addr == WB_ADDR_W'(cache_mem_address))) begin
                hit_c      = 1'b1;
                hit_data_c = DATA_W'(entries[idx_c].data);
            end
        end
    end

    // Accept only in IDLE, never while full for writes or on an unforwardable hit
    assign cache_mem_ready = (state_q == IDLE) && !reset
                             && !(is_write_c && full)
                             && !(is_read_c && hit_c && !FWD_EN);

    // Next state and next values of the registered RAM/response outputs
    always_comb begin
        state_d           = state_q;
        push_c            = 1'b0;
        pop_c             = 1'b0;
        start_drain_c     = 1'b0;
        mem_request_d     = mem_request_q;
        mem_we_d          = mem_we_q;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        resp_data_d       = resp_data_q;
        resp_valid_d      = 1'b0;
        push_entry_c.addr = WB_ADDR_W'(cache_mem_address);
        push_entry_c.data = WB_DATA_W'(cache_mem_write_data);
        case (state_q)
            IDLE: begin
                if (is_read_c) begin
                    if (!hit_c) begin
                        state_d       = READ_ISSUE;
                        mem_request_d = 1'b1;
                        mem_we_d      = 1'b0;
                        mem_addr_d    = cache_mem_address;
                    end else if (FWD_EN) begin
                        resp_data_d  = hit_data_c;
                        resp_valid_d = 1'b1;
                    end else begin
                        start_drain_c = 1'b1;
                    end
                end else if (is_write_c) begin
                    if (full) start_drain_c = 1'b1;
                    else      push_c        = 1'b1;
                end else if (count != '0) begin
                    start_drain_c = 1'b1;
                end
            end
            READ_ISSUE: begin
                if (mem_ready) begin
                    state_d       = READ_RESP;
                    mem_request_d = 1'b0;
                end
            end
            READ_RESP: begin
                resp_data_d  = mem_response_data;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            DRAIN: begin
                if (mem_ready) begin
                    pop_c         = 1'b1;
                    state_d       = IDLE;
                    mem_request_d = 1'b0;
                    mem_we_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_drain_c) begin
            state_d       = DRAIN;
            mem_request_d = 1'b1;
            mem_we_d      = 1'b1;
            mem_addr_d    = ADDR_W'(head_entry_c.addr);
            mem_wdata_d   = DATA_W'(head_entry_c.data);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_request_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            resp_data_q   <= '0;
            resp_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_request_q <= mem_request_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            resp_data_q   <= resp_data_d;
            resp_valid_q  <= resp_valid_d;
        end
    end

    assign mem_request             = mem_request_q;
    assign mem_write_enable        = mem_we_q;
    assign mem_address             = mem_addr_q;
    assign mem_write_data          = mem_wdata_q;
    assign cache_mem_response_data = resp_data_q;
    assign cache_mem_resp_valid    = resp_valid_q;
    assign wb_count                = count;
    assign wb_full                 = full;

endmodule

// File: tb/tb_l1_dcache_write_buffer.sv
// Directed bench for l1_dcache_write_buffer with a RAM model and
// write/response scoreboards. Honours L1_WB_FORWARD_EN like the design.
module tb_l1_dcache_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_mem_request, cache_mem_write_enable;
    logic [31:0] cache_mem_address, cache_mem_write_data;
    logic        cache_mem_ready;
    logic [31:0] cache_mem_response_data;
    logic        cache_mem_resp_valid;
    logic        mem_request, mem_write_enable;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_response_data;
    logic        mem_ready;
    logic [2:0]  wb_count;
    logic        wb_full;

    always #5 clk = ~clk;

    l1_dcache_write_buffer dut (
        .clk                     (clk),
        .reset                   (reset),
        .cache_mem_request       (cache_mem_request),
        .cache_mem_write_enable  (cache_mem_write_enable),
        .cache_mem_address       (cache_mem_address),
        .cache_mem_write_data    (cache_mem_write_data),
        .cache_mem_ready         (cache_mem_ready),
        .cache_mem_response_data (cache_mem_response_data),
        .cache_mem_resp_valid    (cache_mem_resp_valid),
        .mem_request             (mem_request),
        .mem_write_enable        (mem_write_enable),
        .mem_address             (mem_address),
        .mem_write_data          (mem_write_data),
        .mem_response_data       (mem_response_data),
        .mem_ready               (mem_ready),
        .wb_count                (wb_count),
        .wb_full                 (wb_full)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] data; int cyc; } rsp_t;

    wr_t         wr_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] ram [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ram_wr_cnt = 0;
    int          ram_rd_cnt = 0;
    int          rd0, wr0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_addr;
    wr_t         w_exp;
    rsp_t        r_exp;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 32'h0;
    endfunction

    // RAM model plus scoreboard consumers, all sampled mid-cycle
    always @(negedge clk) begin
        if (rd_pend) begin
            mem_response_data = ram_rd(rd_addr);
            rd_pend = 1'b0;
        end else begin
            mem_response_data = 32'hBAD0_BAD0;
        end
        if (!reset && mem_request && mem_ready) begin
            if (mem_write_enable) begin
                ram_wr_cnt++;
                ram[mem_address] = mem_write_data;
                checks++;
                assert (wr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL ram_write_unexpected observed=%h expected=none", mem_address);
                end
                if (wr_q.size() != 0) begin
                    w_exp = wr_q.pop_front();
                    chk("drain_addr", mem_address, w_exp.addr);
                    chk("drain_data", mem_write_data, w_exp.data);
                end
            end else begin
                ram_rd_cnt++;
                rd_pend = 1'b1;
                rd_addr = mem_address;
            end
        end
        if (!reset && cache_mem_resp_valid) begin
            checks++;
            assert (rsp_q.size() != 0) else begin
                errors++;
                $error("FAIL resp_unexpected observed=%h expected=none", cache_mem_response_data);
            end
            if (rsp_q.size() != 0) begin
                r_exp = rsp_q.pop_front();
                chk("resp_data", cache_mem_response_data, r_exp.data);
                if (r_exp.cyc >= 0) chk("resp_cycle", 32'(cyc), 32'(r_exp.cyc));
            end
        end
    end

    // All driver tasks start and end one time unit after a rising edge
    task automatic idle();
        cache_mem_request = 1'b0;
    endtask

    task automatic cache_write(input logic [31:0] a, input logic [31:0] d, input int budget);
        bit  acc = 1'b0;
        wr_t e;
        cache_mem_request      = 1'b1;
        cache_mem_write_enable = 1'b1;
        cache_mem_address      = a;
        cache_mem_write_data   = d;
        for (int n = 0; n < budget && !acc; n++) begin
            @(negedge clk);
            if (cache_mem_ready) begin
                acc = 1'b1;
                e.addr = a;
                e.data = d;
                wr_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL write_accept_%h observed=timeout expected=accept", a);
        end
    endtask

    task automatic cache_read(input logic [31:0] a, input logic [31:0] d, input int lat, input int budget);
        bit   acc = 1'b0;
        rsp_t r;
        cache_mem_request      = 1'b1;
        cache_mem_write_enable = 1'b0;
        cache_mem_address      = a;
        for (int n = 0; n < budget && !acc; n++) begin
            @(negedge clk);
            if (cache_mem_ready) begin
                acc    = 1'b1;
                r.data = d;
                r.cyc  = (lat > 0) ? cyc + lat : -1;
                rsp_q.push_back(r);
            end
            @(posedge clk); #1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL read_accept_%h observed=timeout expected=accept", a);
        end
    endtask

    task automatic wait_count_zero(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (wb_count == 3'd0 && wr_q.size() == 0) break;
        end
        chk(tag, 32'(wb_count), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (rsp_q.size() == 0) break;
        end
        chk(tag, 32'(rsp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b1;
        cache_mem_request      = 1'b0;
        cache_mem_write_enable = 1'b0;
        cache_mem_address      = '0;
        cache_mem_write_data   = '0;
        mem_ready              = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_request", 32'(mem_request), 32'd0);
        chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_resp_data", cache_mem_response_data, 32'd0);
        chk("rst_resp_valid", 32'(cache_mem_resp_valid), 32'd0);
        chk("rst_wb_count", 32'(wb_count), 32'd0);
        chk("rst_wb_full", 32'(wb_full), 32'd0);
        chk("rst_ready", 32'(cache_mem_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cache_mem_ready), 32'd1);
        chk("post_rst_count", 32'(wb_count), 32'd0);
        @(posedge clk); #1;

        // Single write then idle drain
        cache_write(32'h200, 32'hBEEF_DEAD, 5);
        idle();
        @(negedge clk);
        chk("single_count", 32'(wb_count), 32'd1);
        @(posedge clk); #1;
        wait_count_zero("single_drain_count", 20);
        chk("single_ram", ram_rd(32'h200), 32'hBEEF_DEAD);

        // Fill to full with RAM stalled, fifth write held off, ordered drains
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cache_write(32'h200 + 32'(i), 32'hA000_0000 + 32'(i), 5);
        cache_mem_request      = 1'b1;
        cache_mem_write_enable = 1'b1;
        cache_mem_address      = 32'h204;
        cache_mem_write_data   = 32'hA000_0004;
        @(negedge clk);
        chk("full_flag", 32'(wb_full), 32'd1);
        chk("full_count", 32'(wb_count), 32'd4);
        chk("full_ready", 32'(cache_mem_ready), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        cache_write(32'h204, 32'hA000_0004, 20);
        idle();
        wait_count_zero("burst_drain_count", 60);
        chk("burst_ram_203", ram_rd(32'h203), 32'hA000_0003);

        // Read hitting two buffered writes to the same address
        mem_ready = 1'b0;
        cache_write(32'h20C, 32'h1111_1111, 5);
        cache_write(32'h20C, 32'h2222_2222, 5);
        rd0 = ram_rd_cnt;
        wr0 = ram_wr_cnt;
`ifdef L1_WB_FORWARD_EN
        cache_read(32'h20C, 32'h2222_2222, 1, 5);
        idle();
        wait_rsp("fwd_rsp", 10);
        chk("fwd_no_ram_read", 32'(ram_rd_cnt - rd0), 32'd0);
        chk("fwd_count", 32'(wb_count), 32'd2);
        mem_ready = 1'b1;
        wait_count_zero("fwd_drain_count", 40);
`else
        cache_mem_request      = 1'b1;
        cache_mem_write_enable = 1'b0;
        cache_mem_address      = 32'h20C;
        @(negedge clk);
        chk("hit_hold_ready", 32'(cache_mem_ready), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        cache_read(32'h20C, 32'h2222_2222, 0, 60);
        idle();
        wait_rsp("hold_rsp", 20);
        chk("hold_drains", 32'(ram_wr_cnt - wr0), 32'd2);
        chk("hold_ram_read", 32'(ram_rd_cnt - rd0), 32'd1);
        chk("hold_count", 32'(wb_count), 32'd0);
`endif

        // Buffer-miss read, latency 3 with RAM ready
        ram[32'h3FF] = 32'h1111_1111;
        cache_read(32'h3FF, 32'h1111_1111, 3, 5);
        idle();
        wait_rsp("miss_rsp", 10);

        // Reset in the middle of a stalled drain with three entries
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cache_write(32'h300 + 32'(i), 32'hC000_0000 + 32'(i), 5);
        idle();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_request) break;
        end
        chk("drain_started", 32'(mem_request), 32'd1);
        chk("drain_we", 32'(mem_write_enable), 32'd1);
        chk("drain_head_addr", mem_address, 32'h300);
        chk("drain_count3", 32'(wb_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_mem_request", 32'(mem_request), 32'd0);
        chk("midrst_count", 32'(wb_count), 32'd0);
        chk("midrst_full", 32'(wb_full), 32'd0);
        chk("midrst_ready", 32'(cache_mem_ready), 32'd0);
        wr_q.delete();
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("postrst_no_request", 32'(mem_request), 32'd0);
        end
        chk("postrst_ready", 32'(cache_mem_ready), 32'd1);
        chk("postrst_count", 32'(wb_count), 32'd0);

        chk("end_wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
